multi_channel_deadtime_pwm: RTL and testbench
=============================================

// Module: multi_channel_deadtime_pwm
// PURPOSE
//   Multi-channel PWM generator with complementary high/low outputs and programmable dead time.
//   One shared counter runs in edge-aligned (sawtooth) or center-aligned (triangle) mode.
//   Period, mode, duty and dead time are double-buffered; new values take effect only at the cycle boundary.
//   Drives half-bridge gate signals (one pwm_h/pwm_l pair per leg).
// PARAMETERS
//   CHANNELS   4  number of PWM channels (complementary pairs)
//   CNT_WIDTH  8  width of the counter, period and each duty value
//   DT_WIDTH   4  width of the dead-time value, in clk cycles
// PORTS
//   clk          in   1                   clock
//   rst          in   1                   synchronous, active-high reset
//   enable       in   1                   1 = run; 0 = counter held at 0, outputs off
//   mode         in   1                   0 = edge-aligned, 1 = center-aligned (shadowed)
//   period       in   CNT_WIDTH           counter top value P (shadowed)
//   duty         in   CHANNELS*CNT_WIDTH  per-channel duty; channel i = duty[i*CNT_WIDTH +: CNT_WIDTH] (shadowed)
//   dead_time    in   DT_WIDTH            dead band D, in cycles (shadowed)
//   cycle_start  out  1                   1-cycle pulse on each shadow load
//   pwm_h        out  CHANNELS            high-side outputs
//   pwm_l        out  CHANNELS            low-side outputs
// BEHAVIOUR
//   Reset: counter=0, dir=up, all active regs=0, dead counters=0, pwm_h=pwm_l=0, cycle_start=0.
//   Shadow load: in every cycle with enable=1 and counter==0, latch mode/period/duty/dead_time
//     into the active regs, force dir=up, and pulse cycle_start in that cycle.
//     The load applies from the next cycle; inputs are ignored at all other times.
//   Counter, in each enabled cycle (all widths unsigned, CNT_WIDTH bits):
//     - Edge mode: 0,1,...,P,0,... (P+1 cycles per PWM cycle).
//     - Center mode: 0 up to P, then P-1 down to 1, then 0 (2P cycles per PWM cycle).
//     - P==0: the counter holds 0 and a shadow load occurs every cycle.
//   Compare stage (registered): raw_q[i] <= (counter < duty_i).
//     - No special cases: duty 0 gives 0%; duty > P gives 100%.
//   Dead-time stage (registered, one FSM per channel; states OFF, DEAD, ON_H, ON_L):
//     - raw_q[i] differs from the side currently driven: go to DEAD, load dcnt=D-1,
//       drive both outputs 0 for D cycles, then enter ON_H (raw=1) or ON_L (raw=0).
//     - raw_q changes while in DEAD: reload dcnt=D-1 and retarget to the new raw value,
//       so pulses shorter than D are swallowed.
//     - D==0: outputs follow raw_q directly (pwm_h=raw_q, pwm_l=~raw_q) with no gap.
//   Invariant: pwm_h & pwm_l == 0 in every cycle.
//   Latency: counter value to pwm_h/pwm_l is 2 cycles when D==0.
//   enable=0: counter=0, dir=up, no shadow load, all FSMs go to OFF (both outputs 0),
//     cycle_start=0. Leaving OFF passes through DEAD using the active D.
//   rst mid-cycle: all state returns to reset values on the next edge; rst overrides enable.
// TESTING
//   1. CH=2, edge, P=9, duty0=3, duty1=0, D=0 -> pwm_h[0] high 3 of every 10 cycles; pwm_l[0]=~pwm_h[0]; pwm_h[1]=0; cycle_start every 10 cycles.
//   2. Center, P=4, duty0=2, D=1 -> counter 0,1,2,3,4,3,2,1,0; raw high at counts 0,1,1,0; one-cycle both-low gap at every transition.
//   3. Edge, P=9, duty0 changed 3->7 mid-cycle -> width stays 3 until the next cycle_start, then becomes 7.
//   4. duty0=P+1 -> pwm_h[0] stays 1 after the initial dead band; duty0=0 -> pwm_l[0] stays 1.
//   5. Center, P=4, duty0=1, D=5 -> raw pulse (1 cycle) is shorter than D; pwm_h[0] never asserts; pwm_h&pwm_l==0 throughout.
//   6. rst or enable=0 asserted mid-cycle -> next cycle pwm_h=pwm_l=0, counter=0; on re-enable, cycle_start fires on the first enabled cycle.

Source files
------------

// File: rtl/multi_channel_deadtime_pwm.sv
// Multi-channel complementary PWM with a shared edge/center-aligned counter, double-buffered
// settings and per-channel dead-time insertion for half-bridge gate drive.
module multi_channel_deadtime_pwm #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned DT_WIDTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          mode,
  input  logic [CNT_WIDTH-1:0]          period,
  input  logic [CHANNELS*CNT_WIDTH-1:0] duty,
  input  logic [DT_WIDTH-1:0]           dead_time,
  output logic                          cycle_start,
  output logic [CHANNELS-1:0]           pwm_h,
  output logic [CHANNELS-1:0]           pwm_l
);

  typedef enum logic [1:0] {StOff, StDead, StOnH, StOnL} st_e;

  logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
  logic                          dir_up_q, dir_up_d;
  logic                          mode_q;
  logic [CNT_WIDTH-1:0]          period_q;
  logic [CHANNELS*CNT_WIDTH-1:0] duty_q;
  logic [DT_WIDTH-1:0]           dt_q;
  logic [CHANNELS-1:0]           raw_q, raw_d;
  logic [CHANNELS-1:0]           tgt_q, tgt_d;
  logic [CHANNELS-1:0]           pwm_h_q, pwm_h_d, pwm_l_q, pwm_l_d;
  st_e                           st_q [CHANNELS];
  st_e                           st_d [CHANNELS];
  logic [DT_WIDTH-1:0]           dcnt_q [CHANNELS];
  logic [DT_WIDTH-1:0]           dcnt_d [CHANNELS];
  logic                          load;

  assign load        = enable && (cnt_q == '0);
  assign cycle_start = load && !rst;
  assign pwm_h       = pwm_h_q;
  assign pwm_l       = pwm_l_q;

  // A zero count is always treated as counting up, so the turn-around at the bottom of a
  // center-aligned cycle needs no extra state.
  always_comb begin
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    if (!enable) begin
      cnt_d    = '0;
      dir_up_d = 1'b1;
    end else if (period_q == '0 && cnt_q == '0) begin
      cnt_d    = '0;
      dir_up_d = 1'b1;
    end else if (!mode_q) begin
      cnt_d    = (cnt_q >= period_q) ? '0 : cnt_q + 1'b1;
      dir_up_d = 1'b1;
    end else if (dir_up_q || cnt_q == '0) begin
      if (cnt_q >= period_q) begin
        cnt_d    = cnt_q - 1'b1;
        dir_up_d = 1'b0;
      end else begin
        cnt_d    = cnt_q + 1'b1;
        dir_up_d = 1'b1;
      end
    end else begin
      cnt_d    = cnt_q - 1'b1;
      dir_up_d = 1'b0;
    end
  end

  always_comb begin
    raw_d   = '0;
    tgt_d   = tgt_q;
    pwm_h_d = '0;
    pwm_l_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      raw_d[i]  = cnt_q < duty_q[i*CNT_WIDTH +: CNT_WIDTH];
      st_d[i]   = st_q[i];
      dcnt_d[i] = dcnt_q[i];
      if (!enable) begin
        st_d[i]   = StOff;
        dcnt_d[i] = '0;
      end else if (dt_q == '0) begin
        st_d[i]   = raw_q[i] ? StOnH : StOnL;
        dcnt_d[i] = '0;
      end else begin
        case (st_q[i])
          StOff, StOnH, StOnL: begin
            if (st_q[i] == StOff || (st_q[i] == StOnH) != raw_q[i]) begin
              st_d[i]   = StDead;
              dcnt_d[i] = dt_q - 1'b1;
              tgt_d[i]  = raw_q[i];
            end
          end
          StDead: begin
            // A raw edge inside the dead band restarts it, swallowing short pulses.
            if (raw_q[i] != tgt_q[i]) begin
              dcnt_d[i] = dt_q - 1'b1;
              tgt_d[i]  = raw_q[i];
            end else if (dcnt_q[i] == '0) begin
              st_d[i] = tgt_q[i] ? StOnH : StOnL;
            end else begin
              dcnt_d[i] = dcnt_q[i] - 1'b1;
            end
          end
          default: st_d[i] = StOff;
        endcase
      end
      pwm_h_d[i] = (st_d[i] == StOnH);
      pwm_l_d[i] = (st_d[i] == StOnL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      dir_up_q <= 1'b1;
      mode_q   <= 1'b0;
      period_q <= '0;
      duty_q   <= '0;
      dt_q     <= '0;
      raw_q    <= '0;
      tgt_q    <= '0;
      pwm_h_q  <= '0;
      pwm_l_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        st_q[i]   <= StOff;
        dcnt_q[i] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      dir_up_q <= dir_up_d;
      raw_q    <= raw_d;
      tgt_q    <= tgt_d;
      pwm_h_q  <= pwm_h_d;
      pwm_l_q  <= pwm_l_d;
      for (int i = 0; i < CHANNELS; i++) begin
        st_q[i]   <= st_d[i];
        dcnt_q[i] <= dcnt_d[i];
      end
      if (load) begin
        mode_q   <= mode;
        period_q <= period;
        duty_q   <= duty;
        dt_q     <= dead_time;
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_deadtime_pwm.sv
// Bench for multi_channel_deadtime_pwm: directed runs push expected {pwm_h, pwm_l, cycle_start}
// per cycle into a queue; a monitor pops and compares on each falling edge.
module tb_multi_channel_deadtime_pwm;

  localparam int CH = 2;
  localparam int CW = 8;
  localparam int DW = 4;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             mode;
  logic [CW-1:0]    period;
  logic [CH*CW-1:0] duty;
  logic [DW-1:0]    dead_time;
  logic             cycle_start;
  logic [CH-1:0]    pwm_h;
  logic [CH-1:0]    pwm_l;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int         tst;
    int         cyc;
    logic [4:0] v;  // {pwm_h[1:0], pwm_l[1:0], cycle_start}
  } exp_t;

  exp_t exp_q[$];

  multi_channel_deadtime_pwm #(
    .CHANNELS (CH),
    .CNT_WIDTH(CW),
    .DT_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .period     (period),
    .duty       (duty),
    .dead_time  (dead_time),
    .cycle_start(cycle_start),
    .pwm_h      (pwm_h),
    .pwm_l      (pwm_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter value in cycle x of an edge-aligned P=9 run (x=1 is the first enabled cycle).
  function automatic int cnt_edge(input int x);
    return (x - 2) % 10;
  endfunction

  // Counter value in cycle x of a center-aligned P=4 run.
  function automatic int cnt_ctr(input int x);
    int k;
    k = (x - 2) % 8;
    return (k <= 4) ? k : 8 - k;
  endfunction

  // raw_q for channel 0 in cycle x of a center-aligned P=4 run with duty thr.
  function automatic logic raw_ctr(input int x, input int thr);
    return (x >= 3) && (cnt_ctr(x - 1) < thr);
  endfunction

  function automatic logic cs_ctr(input int c);
    return (c == 1) || ((c >= 2) && ((c - 2) % 8 == 0));
  endfunction

  // Edge P=9, duty0=P+1, duty1=0, D=2, starting from reset state.
  function automatic logic [4:0] exp_t4(input int c);
    logic cs;
    cs = (c == 1) || ((c >= 2) && ((c - 2) % 10 == 0));
    if (c == 1)      return {2'b00, 2'b00, cs};
    else if (c <= 3) return {2'b00, 2'b11, cs};
    else if (c <= 5) return {2'b00, 2'b10, cs};
    else             return {2'b01, 2'b10, cs};
  endfunction

  task automatic cyc(input int tst, input int c, input logic chk, input logic [4:0] v);
    if (chk) exp_q.push_back('{tst: tst, cyc: c, v: v});
    @(posedge clk);
    #1;
  endtask

  task automatic rst_cycle();
    rst    = 1'b1;
    enable = 1'b0;
    cyc(0, 0, 1'b0, 5'b0);
    rst    = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({pwm_h, pwm_l, cycle_start} !== e.v) begin
          errors++;
          $display("FAIL outputs t%0d c%0d: got h=%b l=%b cs=%b, want h=%b l=%b cs=%b",
                   e.tst, e.cyc, pwm_h, pwm_l, cycle_start, e.v[4:3], e.v[2:1], e.v[0]);
        end
        checks++;
        if ((pwm_h & pwm_l) != '0) begin
          errors++;
          $display("FAIL overlap t%0d c%0d: got h&l=%b, want 00", e.tst, e.cyc, pwm_h & pwm_l);
        end
      end
    end
  end

  initial begin
    logic h0, l0, r1, r2, l1;
    int   x;
    rst = 1'b1; enable = 1'b0; mode = 1'b0; period = '0; duty = '0; dead_time = '0;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 2; c++) cyc(0, c, 1'b1, 5'b0);

    // Edge P=9, duty0=3 then 7 mid-cycle, duty1=0, D=0.
    rst = 1'b0; enable = 1'b1; mode = 1'b0; period = 8'd9; duty = {8'd0, 8'd3}; dead_time = 4'd0;
    for (int c = 1; c <= 61; c++) begin
      if (c == 35) duty[7:0] = 8'd7;
      x  = c - 2;
      h0 = (c >= 4) && (cnt_edge(x) < ((x >= 43) ? 7 : 3));
      cyc(1, c, 1'b1, {1'b0, h0, (c >= 2) ? {1'b1, ~h0} : 2'b00,
                       (c == 1) || ((c >= 2) && ((c - 2) % 10 == 0))});
    end

    // Center P=4, duty0=2, D=1.
    rst_cycle();
    enable = 1'b1; mode = 1'b1; period = 8'd4; duty = {8'd0, 8'd2}; dead_time = 4'd1;
    for (int c = 1; c <= 30; c++) begin
      r1 = raw_ctr(c - 1, 2);
      r2 = raw_ctr(c - 2, 2);
      if (c == 1)        begin h0 = 1'b0; l0 = 1'b0; end
      else if (c == 2)   begin h0 = 1'b0; l0 = 1'b1; end
      else if (r1 != r2) begin h0 = 1'b0; l0 = 1'b0; end
      else               begin h0 = r1;   l0 = ~r1;  end
      l1 = (c >= 2);
      cyc(2, c, 1'b1, {1'b0, h0, l1, l0, cs_ctr(c)});
    end

    // Center P=4, duty0=1, D=5: the one-cycle raw pulse is swallowed.
    rst_cycle();
    enable = 1'b1; mode = 1'b1; period = 8'd4; duty = {8'd0, 8'd1}; dead_time = 4'd5;
    for (int c = 1; c <= 30; c++) begin
      if (c == 1)      l0 = 1'b0;
      else if (c <= 3) l0 = 1'b1;
      else             l0 = ((c - 4) % 8) >= 6;
      l1 = (c >= 2);
      cyc(5, c, 1'b1, {2'b00, l1, l0, cs_ctr(c)});
    end

    // Edge P=9, duty0=P+1, duty1=0, D=2; then enable drop, re-enable, and rst mid-cycle.
    rst_cycle();
    enable = 1'b1; mode = 1'b0; period = 8'd9; duty = {8'd0, 8'd10}; dead_time = 4'd2;
    for (int c = 1; c <= 50; c++) begin
      rst    = (c == 35);
      enable = !(c == 26 || c == 27);
      if (c <= 25)      cyc(4, c, 1'b1, exp_t4(c));
      else if (c == 26) cyc(6, c, 1'b1, {2'b01, 2'b10, 1'b0});
      else if (c == 27) cyc(6, c, 1'b1, 5'b0);
      else if (c <= 30) cyc(6, c, 1'b1, {4'b0000, c == 28});
      else if (c <= 35) cyc(6, c, 1'b1, {2'b01, 2'b10, 1'b0});
      else              cyc(6, c, 1'b1, exp_t4(c - 35));
    end

    repeat (2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
